exe_arb_w15: RTL and testbench
==============================

Name: exe_arb_w15

Overview:
- Sequencer and round-robin arbiter that shares one exe_unit_w15 instance between two requesters.
- Accepts a level request with held operands from each requester and issues one operation at a time to the execution unit.
- Waits the unit's fixed latency, captures o_result/o_status and returns them to the owner with a one-cycle acknowledge.
- Sits between the two client blocks and the execution unit; drives its i_oper/i_argA/i_argB.

Parameters:
- ARG_BITS, 4, operand/result width; must match the execution unit's ARG_BITS.
- EXE_LAT, 1, clock edges from operands valid at the unit's inputs to result valid at its outputs; legal range 1..4.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  asynchronous, active-high reset.
- i_req0 / i_req1  in  1  request level; operands must stay stable until the matching ack.
- i_oper0 / i_oper1  in  2  operation code.
- i_argA0 / i_argA1  in  ARG_BITS  operand A.
- i_argB0 / i_argB1  in  ARG_BITS  operand B.
- o_ack0 / o_ack1  out  1  one-cycle completion pulse.
- o_result0 / o_result1  out  ARG_BITS  captured result; held until the next ack to that requester.
- o_status0 / o_status1  out  4  captured status; held the same way.
- o_exe_oper  out  2  to execution unit i_oper.
- o_exe_argA / o_exe_argB  out  ARG_BITS  to execution unit i_argA/i_argB.
- i_exe_result  in  ARG_BITS  from execution unit o_result.
- i_exe_status  in  4  from execution unit o_status.
- o_busy  out  1  high when state is not IDLE.
- o_grant  out  1  index of current/last owner.

Behaviour:
- Reset (asynchronous, i_rst=1): all outputs 0, state IDLE, wait counter 0, round-robin pointer "last"=1 (req0 wins the first tie).
- States: IDLE, WAIT, DONE.
- IDLE, no request: stay in IDLE; o_exe_* hold the last issued values.
- IDLE, at least one request in cycle T:
  - Select the owner. A single request is granted. If both request, grant the index opposite to "last".
  - At the edge: latch the owner's oper/argA/argB into o_exe_*, set o_grant and "last" to the owner, load counter=EXE_LAT, go to WAIT.
  - o_exe_* are valid from cycle T+1.
- WAIT:
  - Decrement the counter each cycle.
  - In cycle T+1+EXE_LAT (counter==0): sample i_exe_result/i_exe_status into the owner's o_resultN/o_statusN, go to DONE.
- DONE (cycle T+2+EXE_LAT): o_ackN=1 for the owner only, for one cycle; next state IDLE.
- Issue period is EXE_LAT+3 cycles per operation.
- The non-owner's result/status registers never change.
- A request still high in the IDLE cycle after its ack is a new request.
- Arbitration happens only in IDLE. Requests arriving during WAIT/DONE wait; there is no queueing beyond the request level.
- Request dropped during WAIT/DONE: the operation completes and the ack still pulses once; no reissue.
- Reset mid-operation: the operation is discarded and no ack is produced. A request held through reset is reissued from IDLE after release; req0 has priority again.
- Operands are not checked for change after grant; only the values latched at grant are used.

Optional Feature:
- Macro ARB_STATS_EN.
- Defined:
  - Adds ports o_cnt0 and o_cnt1 (out, 8 bits).
  - Each is a per-requester count of completed operations, incremented in the DONE cycle and saturating at 255.
  - Both are cleared by i_rst.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Bench setup: stub execution unit with EXE_LAT register stages, result = argA^argB, status = {2'b00, oper}.
- Reset: hold i_rst=1 with random inputs -> all outputs 0, o_busy=0; assert i_rst mid-WAIT -> outputs 0 immediately, no ack.
- Single request, EXE_LAT=1: i_req0=1, oper=2'b10, A=3, B=5 at cycle T -> o_exe_argA=3, o_exe_argB=5 at T+1; o_ack0 pulse at T+3 with o_result0=6, o_status0=4'b0010; o_ack1 stays 0.
- Contention: i_req0 and i_req1 both held high from reset release, four completions -> grant order 0,1,0,1; acks exactly 4 cycles apart.
- EXE_LAT=3: single i_req1 at T -> o_ack1 at T+5; o_busy high T+1..T+5.
- Request drop and reset recovery:
  - i_req0 deasserted during WAIT -> one o_ack0 pulse, then IDLE, no reissue.
  - Reset during WAIT with i_req1 held -> reissued after release, ack arrives.
- ARB_STATS_EN: 300 back-to-back req0 operations -> o_cnt0=255, o_cnt1=0; after reset both 0.

Source files
------------

// File: rtl/exe_arb_w15_if.sv
// exe_arb_w15_if
// Bundles every non-clock, non-reset signal of the exe_arb_w15 arbiter into one interface.
//
// Signal names keep the arbiter's point of view: i_* are driven into the arbiter and
// o_* are driven by it.
//   Requester side   : i_req0/1, i_oper0/1, i_argA0/1, i_argB0/1,
//                      o_ack0/1, o_result0/1, o_status0/1
//   Execution unit   : o_exe_oper, o_exe_argA, o_exe_argB, i_exe_result, i_exe_status
//   Observation      : o_busy, o_grant
//   With ARB_STATS_EN: o_cnt0, o_cnt1
//
// Modports:
//   slave  - the arbiter
//   master - the surroundings (clients, execution unit, bench)
//
// Optional feature macro: ARB_STATS_EN (adds the o_cnt0/o_cnt1 completion counters).

interface exe_arb_w15_if #(
  parameter int ARG_BITS = 4
);
  logic                i_req0;
  logic                i_req1;
  logic [1:0]          i_oper0;
  logic [1:0]          i_oper1;
  logic [ARG_BITS-1:0] i_argA0;
  logic [ARG_BITS-1:0] i_argA1;
  logic [ARG_BITS-1:0] i_argB0;
  logic [ARG_BITS-1:0] i_argB1;
  logic                o_ack0;
  logic                o_ack1;
  logic [ARG_BITS-1:0] o_result0;
  logic [ARG_BITS-1:0] o_result1;
  logic [3:0]          o_status0;
  logic [3:0]          o_status1;
  logic [1:0]          o_exe_oper;
  logic [ARG_BITS-1:0] o_exe_argA;
  logic [ARG_BITS-1:0] o_exe_argB;
  logic [ARG_BITS-1:0] i_exe_result;
  logic [3:0]          i_exe_status;
  logic                o_busy;
  logic                o_grant;
`ifdef ARB_STATS_EN
  logic [7:0]          o_cnt0;
  logic [7:0]          o_cnt1;
`endif

  modport slave (
    input  i_req0, i_req1, i_oper0, i_oper1, i_argA0, i_argA1, i_argB0, i_argB1,
    input  i_exe_result, i_exe_status,
    output o_ack0, o_ack1, o_result0, o_result1, o_status0, o_status1,
    output o_exe_oper, o_exe_argA, o_exe_argB, o_busy, o_grant
`ifdef ARB_STATS_EN
    , output o_cnt0, o_cnt1
`endif
  );

  modport master (
    output i_req0, i_req1, i_oper0, i_oper1, i_argA0, i_argA1, i_argB0, i_argB1,
    output i_exe_result, i_exe_status,
    input  o_ack0, o_ack1, o_result0, o_result1, o_status0, o_status1,
    input  o_exe_oper, o_exe_argA, o_exe_argB, o_busy, o_grant
`ifdef ARB_STATS_EN
    , input o_cnt0, o_cnt1
`endif
  );
endinterface

// File: rtl/exe_arb_w15.sv
// exe_arb_w15
// Round-robin sequencer that shares one fixed-latency execution unit between two requesters.
// A requester holds a level request with stable operands. The arbiter grants one owner in
// IDLE, drives the owner's operands to the unit, waits EXE_LAT edges, captures the unit's
// result/status into the owner's output registers, and pulses that owner's ack for one cycle.
// Each operation therefore occupies EXE_LAT+3 cycles.
//
// Parameters:
//   ARG_BITS - operand/result width; must match the execution unit
//   EXE_LAT  - unit latency in clock edges, 1..4
//
// Ports:
//   i_clk  - rising-edge clock
//   i_rst  - asynchronous active-high reset
//   io_bus - exe_arb_w15_if.slave, which carries the requests, operands, acks, results and
//            statuses, the execution-unit drive and return, and busy/grant
//
// Optional feature macro: ARB_STATS_EN adds o_cnt0/o_cnt1, two saturating 8-bit counts of
// completed operations per requester.

module exe_arb_w15 #(
  parameter int ARG_BITS = 4,
  parameter int EXE_LAT  = 1
) (
  input  logic         i_clk,
  input  logic         i_rst,
  exe_arb_w15_if.slave io_bus
);

  localparam int CNT_W = $clog2(EXE_LAT + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t              r_state;
  logic [CNT_W-1:0]    r_waitCnt;
  logic                r_last;
  logic                r_grant;
  logic                r_busy;
  logic                r_ack0;
  logic                r_ack1;
  logic [1:0]          r_exeOper;
  logic [ARG_BITS-1:0] r_exeArgA;
  logic [ARG_BITS-1:0] r_exeArgB;
  logic [ARG_BITS-1:0] r_result0;
  logic [ARG_BITS-1:0] r_result1;
  logic [3:0]          r_status0;
  logic [3:0]          r_status1;
`ifdef ARB_STATS_EN
  logic [7:0]          r_opCnt0;
  logic [7:0]          r_opCnt1;
`endif

  logic w_anyReq;
  logic w_pick;

  // On a tie, the requester that did not own the unit last time wins. A lone request
  // always wins.
  assign w_anyReq = io_bus.i_req0 | io_bus.i_req1;
  assign w_pick   = (io_bus.i_req0 & io_bus.i_req1) ? ~r_last : io_bus.i_req1;

  // The sequencer registers every output. Operands are latched once at grant. The wait
  // counter runs from EXE_LAT down to 0, and the unit's outputs are sampled in the cycle
  // where it reads 0.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= ST_IDLE;
      r_waitCnt <= '0;
      r_last    <= 1'b1;
      r_grant   <= 1'b0;
      r_busy    <= 1'b0;
      r_ack0    <= 1'b0;
      r_ack1    <= 1'b0;
      r_exeOper <= '0;
      r_exeArgA <= '0;
      r_exeArgB <= '0;
      r_result0 <= '0;
      r_result1 <= '0;
      r_status0 <= '0;
      r_status1 <= '0;
`ifdef ARB_STATS_EN
      r_opCnt0  <= '0;
      r_opCnt1  <= '0;
`endif
    end else begin
      r_ack0 <= 1'b0;
      r_ack1 <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_anyReq) begin
            r_exeOper <= w_pick ? io_bus.i_oper1 : io_bus.i_oper0;
            r_exeArgA <= w_pick ? io_bus.i_argA1 : io_bus.i_argA0;
            r_exeArgB <= w_pick ? io_bus.i_argB1 : io_bus.i_argB0;
            r_grant   <= w_pick;
            r_last    <= w_pick;
            r_waitCnt <= CNT_W'(EXE_LAT);
            r_busy    <= 1'b1;
            r_state   <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (r_waitCnt == '0) begin
            if (r_grant) begin
              r_result1 <= io_bus.i_exe_result;
              r_status1 <= io_bus.i_exe_status;
              r_ack1    <= 1'b1;
            end else begin
              r_result0 <= io_bus.i_exe_result;
              r_status0 <= io_bus.i_exe_status;
              r_ack0    <= 1'b1;
            end
            r_state <= ST_DONE;
          end else begin
            r_waitCnt <= r_waitCnt - CNT_W'(1);
          end
        end
        ST_DONE: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
`ifdef ARB_STATS_EN
          if (r_grant) begin
            if (r_opCnt1 != 8'hFF) r_opCnt1 <= r_opCnt1 + 8'd1;
          end else begin
            if (r_opCnt0 != 8'hFF) r_opCnt0 <= r_opCnt0 + 8'd1;
          end
`endif
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Drive the outputs straight from the registers.
  assign io_bus.o_ack0      = r_ack0;
  assign io_bus.o_ack1      = r_ack1;
  assign io_bus.o_result0   = r_result0;
  assign io_bus.o_result1   = r_result1;
  assign io_bus.o_status0   = r_status0;
  assign io_bus.o_status1   = r_status1;
  assign io_bus.o_exe_oper  = r_exeOper;
  assign io_bus.o_exe_argA  = r_exeArgA;
  assign io_bus.o_exe_argB  = r_exeArgB;
  assign io_bus.o_busy      = r_busy;
  assign io_bus.o_grant     = r_grant;
`ifdef ARB_STATS_EN
  assign io_bus.o_cnt0      = r_opCnt0;
  assign io_bus.o_cnt1      = r_opCnt1;
`endif

endmodule

// File: tb/tb_exe_arb_w15.sv
// tb_exe_arb_w15
// Testbench for exe_arb_w15. It builds two arbiters, one with EXE_LAT=1 and one with
// EXE_LAT=3. Each drives a stub execution unit: EXE_LAT register stages computing
// result = argA ^ argB and status = {2'b00, oper}.
// A transaction-level model predicts every output in every cycle from the grant cycle and
// the latency alone. Directed scenarios come first, then random client traffic.
// With ARB_STATS_EN defined it also covers the completion counters.

module tb_exe_arb_w15;

  logic clk;
  logic rst;

  logic       req  [2][2];
  logic [1:0] oper [2][2];
  logic [3:0] argA [2][2];
  logic [3:0] argB [2][2];

  logic       obsAck  [2][2];
  logic [3:0] obsRes  [2][2];
  logic [3:0] obsStat [2][2];
  logic       obsBusy [2];
  logic       obsGrant[2];
  logic [1:0] obsExeOper[2];
  logic [3:0] obsExeA [2];
  logic [3:0] obsExeB [2];
`ifdef ARB_STATS_EN
  logic [7:0] obsCnt  [2][2];
`endif

  // Each instance has its own interface, arbiter and stub execution unit.
  for (genvar g = 0; g < 2; g++) begin : gInst
    localparam int LAT = (g == 0) ? 1 : 3;
    exe_arb_w15_if #(.ARG_BITS(4)) ifc ();
    logic [7:0] pipe [LAT];

    exe_arb_w15 #(.ARG_BITS(4), .EXE_LAT(LAT)) dut (
      .i_clk (clk),
      .i_rst (rst),
      .io_bus(ifc)
    );

    assign ifc.i_req0       = req[g][0];
    assign ifc.i_req1       = req[g][1];
    assign ifc.i_oper0      = oper[g][0];
    assign ifc.i_oper1      = oper[g][1];
    assign ifc.i_argA0      = argA[g][0];
    assign ifc.i_argA1      = argA[g][1];
    assign ifc.i_argB0      = argB[g][0];
    assign ifc.i_argB1      = argB[g][1];
    assign ifc.i_exe_result = pipe[LAT-1][7:4];
    assign ifc.i_exe_status = pipe[LAT-1][3:0];

    always @(posedge clk) begin
      pipe[0] <= {ifc.o_exe_argA ^ ifc.o_exe_argB, 2'b00, ifc.o_exe_oper};
      for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
    end
  end

  // Copy both instances' outputs into plain arrays so they can be indexed.
  always_comb begin
    obsAck[0][0]  = gInst[0].ifc.o_ack0;      obsAck[0][1]  = gInst[0].ifc.o_ack1;
    obsRes[0][0]  = gInst[0].ifc.o_result0;   obsRes[0][1]  = gInst[0].ifc.o_result1;
    obsStat[0][0] = gInst[0].ifc.o_status0;   obsStat[0][1] = gInst[0].ifc.o_status1;
    obsBusy[0]    = gInst[0].ifc.o_busy;      obsGrant[0]   = gInst[0].ifc.o_grant;
    obsExeOper[0] = gInst[0].ifc.o_exe_oper;
    obsExeA[0]    = gInst[0].ifc.o_exe_argA;  obsExeB[0]    = gInst[0].ifc.o_exe_argB;
    obsAck[1][0]  = gInst[1].ifc.o_ack0;      obsAck[1][1]  = gInst[1].ifc.o_ack1;
    obsRes[1][0]  = gInst[1].ifc.o_result0;   obsRes[1][1]  = gInst[1].ifc.o_result1;
    obsStat[1][0] = gInst[1].ifc.o_status0;   obsStat[1][1] = gInst[1].ifc.o_status1;
    obsBusy[1]    = gInst[1].ifc.o_busy;      obsGrant[1]   = gInst[1].ifc.o_grant;
    obsExeOper[1] = gInst[1].ifc.o_exe_oper;
    obsExeA[1]    = gInst[1].ifc.o_exe_argA;  obsExeB[1]    = gInst[1].ifc.o_exe_argB;
  end
`ifdef ARB_STATS_EN
  always_comb begin
    obsCnt[0][0] = gInst[0].ifc.o_cnt0;  obsCnt[0][1] = gInst[0].ifc.o_cnt1;
    obsCnt[1][0] = gInst[1].ifc.o_cnt0;  obsCnt[1][1] = gInst[1].ifc.o_cnt1;
  end
`endif

  // Free-running clock; rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checkCnt;
  int passCnt;
  int cyc;

  // Model state per instance. An operation is described only by its grant cycle, its
  // owner and the operands latched at grant.
  bit         mActive[2];
  int         mStart [2];
  bit         mOwner [2];
  bit         mLast  [2];
  bit         mGrant [2];
  logic [1:0] mExeOper[2];
  logic [3:0] mExeA  [2];
  logic [3:0] mExeB  [2];
  logic [3:0] mRes   [2][2];
  logic [3:0] mStat  [2][2];
  int         mCnt   [2][2];
  bit         ackSeen[2][2];

  task automatic checkOutput(input string tag, input int unsigned obs, input int unsigned exp);
    checkCnt++;
    if (obs === exp) passCnt++;
    else $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
  endtask

  function automatic int latOf(input int g);
    return (g == 0) ? 1 : 3;
  endfunction

  task automatic modelReset();
    for (int g = 0; g < 2; g++) begin
      mActive[g] = 1'b0;  mStart[g] = 0;  mOwner[g] = 1'b0;
      mLast[g]   = 1'b1;  mGrant[g] = 1'b0;
      mExeOper[g] = '0;   mExeA[g] = '0;  mExeB[g] = '0;
      for (int r = 0; r < 2; r++) begin
        mRes[g][r] = '0;  mStat[g][r] = '0;  mCnt[g][r] = 0;  ackSeen[g][r] = 1'b0;
      end
    end
  endtask

  // Compare one instance's outputs with the model for the current cycle.
  task automatic modelCompare(input int g);
    bit expAck;
    for (int r = 0; r < 2; r++) begin
      expAck = mActive[g] && (cyc == mStart[g] + latOf(g) + 2) && (mOwner[g] == r[0]);
      ackSeen[g][r] = expAck;
      checkOutput($sformatf("i%0d.ack%0d", g, r), obsAck[g][r], expAck);
      checkOutput($sformatf("i%0d.result%0d", g, r), obsRes[g][r], mRes[g][r]);
      checkOutput($sformatf("i%0d.status%0d", g, r), obsStat[g][r], mStat[g][r]);
`ifdef ARB_STATS_EN
      checkOutput($sformatf("i%0d.cnt%0d", g, r), obsCnt[g][r], mCnt[g][r]);
`endif
    end
    checkOutput($sformatf("i%0d.busy", g), obsBusy[g], mActive[g]);
    checkOutput($sformatf("i%0d.grant", g), obsGrant[g], mGrant[g]);
    checkOutput($sformatf("i%0d.exeOper", g), obsExeOper[g], mExeOper[g]);
    checkOutput($sformatf("i%0d.exeA", g), obsExeA[g], mExeA[g]);
    checkOutput($sformatf("i%0d.exeB", g), obsExeB[g], mExeB[g]);
  endtask

  // Move the model across one rising edge, using the inputs of the cycle that just ended.
  task automatic modelStep();
    if (rst) begin
      modelReset();
      return;
    end
    for (int g = 0; g < 2; g++) begin
      int lat;
      lat = latOf(g);
      if (mActive[g] && cyc == mStart[g] + lat + 1) begin
        mRes[g][mOwner[g]]  = mExeA[g] ^ mExeB[g];
        mStat[g][mOwner[g]] = {2'b00, mExeOper[g]};
      end
      if (mActive[g] && cyc == mStart[g] + lat + 2) begin
        mActive[g] = 1'b0;
        if (mCnt[g][mOwner[g]] < 255) mCnt[g][mOwner[g]]++;
      end else if (!mActive[g] && (req[g][0] || req[g][1])) begin
        if (req[g][0] && req[g][1]) mOwner[g] = !mLast[g];
        else mOwner[g] = req[g][1];
        mLast[g]    = mOwner[g];
        mGrant[g]   = mOwner[g];
        mExeOper[g] = oper[g][mOwner[g]];
        mExeA[g]    = argA[g][mOwner[g]];
        mExeB[g]    = argB[g][mOwner[g]];
        mStart[g]   = cyc;
        mActive[g]  = 1'b1;
      end
    end
  endtask

  // One clock cycle: compare at the falling edge, advance the model at the rising edge,
  // then return 1 time unit after that edge so the caller can drive the next inputs.
  task automatic tick();
    @(negedge clk);
    modelCompare(0);
    modelCompare(1);
    @(posedge clk);
    modelStep();
    cyc++;
    #1;
  endtask

  task automatic newOps(input int g, input int r);
    oper[g][r] = 2'($urandom_range(0, 3));
    argA[g][r] = 4'($urandom_range(0, 15));
    argB[g][r] = 4'($urandom_range(0, 15));
  endtask

  // Assert reset in the middle of a cycle and confirm that the outputs clear at once.
  task automatic assertResetMid();
    #2;
    rst = 1'b1;
    modelReset();
    #1;
    modelCompare(0);
    modelCompare(1);
  endtask

  // A random client: raises requests with fresh operands, and after an ack either
  // re-requests or drops. Occasionally it abandons a request early.
  task automatic applyStimulus(input int g);
    for (int r = 0; r < 2; r++) begin
      if (!req[g][r]) begin
        if ($urandom_range(0, 2) == 0) begin
          req[g][r] = 1'b1;
          newOps(g, r);
        end
      end else if (ackSeen[g][r]) begin
        if ($urandom_range(0, 1) == 1) newOps(g, r);
        else req[g][r] = 1'b0;
      end else if ($urandom_range(0, 29) == 0) begin
        req[g][r] = 1'b0;
      end
    end
  endtask

  task automatic clearReqs();
    for (int g = 0; g < 2; g++)
      for (int r = 0; r < 2; r++) req[g][r] = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got no end of test, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int nAck;
    int ackWho[4];
    int ackCyc[4];
    int ackCnt;
    bit found;

    checkCnt = 0;
    passCnt  = 0;
    cyc      = 0;
    rst      = 1'b1;
    for (int g = 0; g < 2; g++)
      for (int r = 0; r < 2; r++) begin
        req[g][r] = 1'b0;
        newOps(g, r);
      end
    modelReset();

    // Hold reset with random inputs toggling; every output must stay at zero.
    for (int n = 0; n < 5; n++) begin
      for (int g = 0; g < 2; g++)
        for (int r = 0; r < 2; r++) begin
          req[g][r] = 1'($urandom_range(0, 1));
          newOps(g, r);
        end
      tick();
      checkOutput("rst.busy0", obsBusy[0], 0);
      checkOutput("rst.busy1", obsBusy[1], 0);
    end
    clearReqs();
    rst = 1'b0;
    tick();

    // Single request: req0 with oper=2, A=3, B=5 on the latency-1 instance, and the same
    // operands on req1 of the latency-3 instance.
    req[0][0] = 1'b1;  oper[0][0] = 2'b10;  argA[0][0] = 4'd3;  argB[0][0] = 4'd5;
    req[1][1] = 1'b1;  oper[1][1] = 2'b10;  argA[1][1] = 4'd3;  argB[1][1] = 4'd5;
    tick();
    checkOutput("single.exeA", obsExeA[0], 3);
    checkOutput("single.exeB", obsExeB[0], 5);
    checkOutput("single.exeOper", obsExeOper[0], 2);
    checkOutput("lat3.busyT1", obsBusy[1], 1);
    tick();
    tick();
    checkOutput("single.ack0", obsAck[0][0], 1);
    checkOutput("single.result0", obsRes[0][0], 6);
    checkOutput("single.status0", obsStat[0][0], 2);
    checkOutput("single.ack1", obsAck[0][1], 0);
    checkOutput("lat3.busyT3", obsBusy[1], 1);
    req[0][0] = 1'b0;
    tick();
    checkOutput("lat3.ackT4", obsAck[1][1], 0);
    tick();
    checkOutput("lat3.ackT5", obsAck[1][1], 1);
    checkOutput("lat3.busyT5", obsBusy[1], 1);
    checkOutput("lat3.result1", obsRes[1][1], 6);
    req[1][1] = 1'b0;
    tick();
    checkOutput("lat3.busyT6", obsBusy[1], 0);
    checkOutput("lat3.ackT6", obsAck[1][1], 0);

    // Contention: both requests are held through reset release. Grants must alternate,
    // starting with req0, and the acks must be exactly 4 cycles apart.
    rst = 1'b1;
    modelReset();
    req[0][0] = 1'b1;  req[0][1] = 1'b1;
    newOps(0, 0);
    newOps(0, 1);
    tick();
    rst  = 1'b0;
    nAck = 0;
    for (int n = 0; n < 40 && nAck < 4; n++) begin
      tick();
      if (obsAck[0][0] || obsAck[0][1]) begin
        ackWho[nAck] = obsAck[0][1] ? 1 : 0;
        ackCyc[nAck] = cyc;
        nAck++;
      end
    end
    checkOutput("rr.ackCount", nAck, 4);
    for (int i = 0; i < nAck; i++) begin
      checkOutput($sformatf("rr.order%0d", i), ackWho[i], i % 2);
      if (i > 0) checkOutput($sformatf("rr.gap%0d", i), ackCyc[i] - ackCyc[i-1], 4);
    end
    clearReqs();
    repeat (8) tick();

    // The request is dropped during WAIT: exactly one ack, and no reissue.
    req[0][0] = 1'b1;
    newOps(0, 0);
    tick();
    req[0][0] = 1'b0;
    ackCnt = 0;
    repeat (10) begin
      tick();
      if (obsAck[0][0]) ackCnt++;
    end
    checkOutput("drop.ackCount", ackCnt, 1);
    checkOutput("drop.busyAfter", obsBusy[0], 0);

    // Reset arrives during WAIT while req1 stays high: the operation is discarded, then
    // reissued after reset is released.
    req[1][1] = 1'b1;
    newOps(1, 1);
    tick();
    tick();
    assertResetMid();
    checkOutput("rstWait.busy", obsBusy[1], 0);
    checkOutput("rstWait.ack", obsAck[1][1], 0);
    tick();
    rst   = 1'b0;
    found = 1'b0;
    for (int n = 0; n < 20 && !found; n++) begin
      tick();
      if (obsAck[1][1]) found = 1'b1;
    end
    checkOutput("rstWait.reissue", found, 1);
    checkOutput("rstWait.result", obsRes[1][1], argA[1][1] ^ argB[1][1]);
    req[1][1] = 1'b0;
    repeat (6) tick();

    // Random traffic on both instances, with occasional mid-cycle resets.
    for (int n = 0; n < 800; n++) begin
      if (rst) rst = 1'b0;
      else if ($urandom_range(0, 149) == 0) assertResetMid();
      applyStimulus(0);
      applyStimulus(1);
      tick();
    end

`ifdef ARB_STATS_EN
    // Back-to-back req0 operations must saturate cnt0 at 255. Reset then clears both counts.
    rst = 1'b1;
    modelReset();
    clearReqs();
    tick();
    rst = 1'b0;
    req[0][0] = 1'b1;
    newOps(0, 0);
    repeat (1220) tick();
    checkOutput("stats.cnt0", obsCnt[0][0], 255);
    checkOutput("stats.cnt1", obsCnt[0][1], 0);
    rst = 1'b1;
    modelReset();
    #1;
    checkOutput("stats.cnt0Rst", obsCnt[0][0], 0);
    checkOutput("stats.cnt1Rst", obsCnt[0][1], 0);
    clearReqs();
    tick();
    rst = 1'b0;
    tick();
`endif

    $display("%0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end

endmodule
